// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 daisy-chain bus-functional model:
// register addresses, word size and the Code-B glyph table.
package max7219_pkg;

    localparam int WORD_BITS = 16;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    // Segment order is A..G from bit 6 down to bit 0.
    localparam logic [6:0] GLYPH_0     = 7'h7E;
    localparam logic [6:0] GLYPH_1     = 7'h30;
    localparam logic [6:0] GLYPH_2     = 7'h6D;
    localparam logic [6:0] GLYPH_3     = 7'h79;
    localparam logic [6:0] GLYPH_4     = 7'h33;
    localparam logic [6:0] GLYPH_5     = 7'h5B;
    localparam logic [6:0] GLYPH_6     = 7'h5F;
    localparam logic [6:0] GLYPH_7     = 7'h70;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h7B;
    localparam logic [6:0] GLYPH_DASH  = 7'h01;
    localparam logic [6:0] GLYPH_E     = 7'h4F;
    localparam logic [6:0] GLYPH_H     = 7'h37;
    localparam logic [6:0] GLYPH_L     = 7'h0E;
    localparam logic [6:0] GLYPH_P     = 7'h67;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/max7219_chain_moc_code_b.sv
// Combinational Code-B font: 4-bit value to A..G segment pattern.
module max7219_code_b
    import max7219_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = GLYPH_BLANK;
        case (i_nibble)
            4'h0: o_seg = GLYPH_0;
            4'h1: o_seg = GLYPH_1;
            4'h2: o_seg = GLYPH_2;
            4'h3: o_seg = GLYPH_3;
            4'h4: o_seg = GLYPH_4;
            4'h5: o_seg = GLYPH_5;
            4'h6: o_seg = GLYPH_6;
            4'h7: o_seg = GLYPH_7;
            4'h8: o_seg = GLYPH_8;
            4'h9: o_seg = GLYPH_9;
            4'hA: o_seg = GLYPH_DASH;
            4'hB: o_seg = GLYPH_E;
            4'hC: o_seg = GLYPH_H;
            4'hD: o_seg = GLYPH_L;
            4'hE: o_seg = GLYPH_P;
            default: o_seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/max7219_chain_moc.sv
// Bus-functional model of a chain of MAX7219 drivers, oversampling the
// DIN/CLK/LOAD serial bus and rendering what each device would display.
module max7219_chain_moc
    import max7219_pkg::*;
#(
    parameter int N_DEV       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_serial_din,
    input  logic                 i_serial_clk,
    input  logic                 i_serial_load,
    output logic                 o_serial_dout,
    output logic [N_DEV*64-1:0]  o_digits,
    output logic [N_DEV*4-1:0]   o_intensity,
    output logic [N_DEV-1:0]     o_enable,
    output logic                 o_commit,
    output logic                 o_frame_err,
    output logic                 o_bad_addr
);

    localparam int CHAIN_BITS = N_DEV * WORD_BITS;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_clk_prev;
    logic                   r_load_prev;
    logic                   r_clk_rise;
    logic                   r_load_rise;
    logic                   r_load_lvl;
    logic                   r_din_lvl;

    logic [CHAIN_BITS-1:0]  r_chain;
    logic [3:0]             r_bitcnt;
    logic                   r_commit;
    logic                   r_frame_err;
    logic                   r_bad_addr;
    logic [N_DEV-1:0]       w_bad;

    // Load idles high so leaving reset never looks like a commit edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync  <= '0;
            r_load_sync <= '1;
            r_din_sync  <= '0;
            r_clk_prev  <= 1'b0;
            r_load_prev <= 1'b1;
            r_clk_rise  <= 1'b0;
            r_load_rise <= 1'b0;
            r_load_lvl  <= 1'b1;
            r_din_lvl   <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_serial_clk};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], i_serial_load};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], i_serial_din};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
            r_load_prev <= r_load_sync[SYNC_STAGES-1];
            r_clk_rise  <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
            r_load_rise <= r_load_sync[SYNC_STAGES-1] & ~r_load_prev;
            r_load_lvl  <= r_load_sync[SYNC_STAGES-1];
            r_din_lvl   <= r_din_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain     <= '0;
            r_bitcnt    <= '0;
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
            r_bad_addr  <= 1'b0;
        end else begin
            r_commit    <= r_load_rise;
            r_frame_err <= r_load_rise && (r_bitcnt != 4'd0);
            r_bad_addr  <= r_load_rise && (|w_bad);
            if (r_load_rise) begin
                r_bitcnt <= '0;
            end else if (r_clk_rise && !r_load_lvl) begin
                r_chain  <= {r_chain[CHAIN_BITS-2:0], r_din_lvl};
                r_bitcnt <= r_bitcnt + 4'd1;
            end
        end
    end

    assign o_serial_dout = r_chain[CHAIN_BITS-1];
    assign o_commit      = r_commit;
    assign o_frame_err   = r_frame_err;
    assign o_bad_addr    = r_bad_addr;

    for (genvar d = 0; d < N_DEV; d++) begin : g_dev
        logic [3:0] w_addr;
        logic [7:0] w_data;
        logic [7:0] r_digit [8];
        logic [7:0] r_decode;
        logic [3:0] r_intensity;
        logic [2:0] r_scan;
        logic       r_enable;
        logic       r_test;

        assign w_addr   = r_chain[d*WORD_BITS+8 +: 4];
        assign w_data   = r_chain[d*WORD_BITS +: 8];
        assign w_bad[d] = (w_addr == 4'hD) || (w_addr == 4'hE);

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int k = 0; k < 8; k++) r_digit[k] <= '0;
                r_decode    <= '0;
                r_intensity <= '0;
                r_scan      <= '0;
                r_enable    <= 1'b0;
                r_test      <= 1'b0;
            end else if (r_load_rise) begin
                case (w_addr)
                    ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                    ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                        r_digit[3'(w_addr - 4'd1)] <= w_data;
                    ADDR_DECODE:     r_decode    <= w_data;
                    ADDR_INTENSITY:  r_intensity <= w_data[3:0];
                    ADDR_SCAN_LIMIT: r_scan      <= w_data[2:0];
                    ADDR_SHUTDOWN:   r_enable    <= w_data[0];
                    ADDR_TEST:       r_test      <= w_data[0];
                    default: ;
                endcase
            end
        end

        assign o_intensity[d*4 +: 4] = r_intensity;
        assign o_enable[d]           = r_enable;

        for (genvar k = 0; k < 8; k++) begin : g_digit
            logic [6:0] w_cb;
            logic [7:0] w_seg;

            max7219_code_b u_code_b (
                .i_nibble (r_digit[k][3:0]),
                .o_seg    (w_cb)
            );

            // Display test wins over shutdown, which wins over scan limit.
            assign w_seg = r_test            ? 8'hFF :
                           !r_enable         ? 8'h00 :
                           (3'(k) > r_scan)  ? 8'h00 :
                           r_decode[k]       ? {r_digit[k][7], w_cb} :
                                               r_digit[k];

            assign o_digits[(d*8+k)*8 +: 8] = w_seg;
        end
    end

endmodule

// File: tb/tb_max7219_chain_moc.sv
// Scoreboard bench: one- and three-device chains share the serial bus.
module tb_max7219_chain_moc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic sclk = 1'b0;
    logic load = 1'b1;

    logic         dout1, commit1, ferr1, bad1;
    logic [63:0]  dig1;
    logic [3:0]   int1;
    logic [0:0]   en1;
    logic         dout3, commit3, ferr3, bad3;
    logic [191:0] dig3;
    logic [11:0]  int3;
    logic [2:0]   en3;

    typedef struct {
        logic         chk;
        logic         ferr;
        logic         badr;
        logic [191:0] dig;
        logic [11:0]  inten;
        logic [2:0]   en;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;
    logic hist[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    max7219_chain_moc #(.N_DEV(1), .SYNC_STAGES(2)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_serial_din(din),
        .i_serial_clk(sclk), .i_serial_load(load),
        .o_serial_dout(dout1), .o_digits(dig1), .o_intensity(int1),
        .o_enable(en1), .o_commit(commit1), .o_frame_err(ferr1),
        .o_bad_addr(bad1)
    );

    max7219_chain_moc #(.N_DEV(3), .SYNC_STAGES(2)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_serial_din(din),
        .i_serial_clk(sclk), .i_serial_load(load),
        .o_serial_dout(dout3), .o_digits(dig3), .o_intensity(int3),
        .o_enable(en3), .o_commit(commit3), .o_frame_err(ferr3),
        .o_bad_addr(bad3)
    );

    task automatic check(input string name, input logic [191:0] act,
                         input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (commit1) begin
            if (q1.size() == 0) begin
                check("dev1 unexpected commit", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dev1 frame_err", ferr1, e.ferr);
                check("dev1 bad_addr", bad1, e.badr);
                check("dev1 digits", dig1, e.dig[63:0]);
                check("dev1 intensity", int1, e.inten[3:0]);
                check("dev1 enable", en1, e.en[0:0]);
            end
        end else if (ferr1 || bad1) begin
            check("dev1 pulse without commit", 1, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (commit3) begin
            if (q3.size() == 0) begin
                check("dev3 unexpected commit", 1, 0);
            end else begin
                e = q3.pop_front();
                if (e.chk) begin
                    check("dev3 frame_err", ferr3, e.ferr);
                    check("dev3 bad_addr", bad3, e.badr);
                    check("dev3 digits", dig3, e.dig);
                    check("dev3 intensity", int3, e.inten);
                    check("dev3 enable", en3, e.en);
                end
            end
        end else if (ferr3 || bad3) begin
            check("dev3 pulse without commit", 1, 0);
        end
    end

    task automatic send_bit(input logic b);
        logic exp1, exp3;
        din = b;
        repeat (5) @(negedge clk);
        sclk = 1'b1;
        repeat (5) @(negedge clk);
        sclk = 1'b0;
        hist.push_back(b);
        exp1 = (hist.size() >= 16) ? hist[hist.size()-16] : 1'b0;
        exp3 = (hist.size() >= 48) ? hist[hist.size()-48] : 1'b0;
        check("dev1 dout", dout1, exp1);
        check("dev3 dout", dout3, exp3);
    endtask

    task automatic frame(input int nbits, input logic [47:0] data);
        q1.push_back(e1);
        q3.push_back(e3);
        load = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
        repeat (5) @(negedge clk);
        load = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic x1(input logic f, input logic b, input logic [63:0] d,
                      input logic [3:0] in, input logic en);
        e1 = '{chk: 1'b1, ferr: f, badr: b, dig: {128'h0, d},
               inten: {8'h0, in}, en: {2'b00, en}};
        e3 = '{chk: 1'b0, ferr: 1'b0, badr: 1'b0, dig: '0,
               inten: '0, en: '0};
    endtask

    task automatic do_reset(input logic hold_load);
        load = hold_load;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset digits1", dig1, 0);
        check("reset digits3", dig3, 0);
        check("reset enable", {en3, en1}, 0);
        check("reset intensity", {int3, int1}, 0);
        check("reset dout", {dout3, dout1}, 0);
        check("reset pulses", {commit1, ferr1, bad1, commit3, ferr3, bad3}, 0);
        rst = 1'b0;
        hist.delete();
        repeat (8) @(negedge clk);
        check("post-reset digits", {dig3, dig1}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset(1'b1);

        x1(0, 0, 64'h0, 4'h0, 1);                  frame(16, 48'h0C01);
        x1(0, 0, 64'h0, 4'h0, 1);                  frame(16, 48'h0B07);
        x1(0, 0, 64'h7E7E7E7E7E7E7E7E, 4'h0, 1);   frame(16, 48'h09FF);
        x1(0, 0, 64'h7E7E7E7E7E7E7E5B, 4'h0, 1);   frame(16, 48'h0105);
        x1(0, 0, 64'h05, 4'h0, 1);                 frame(16, 48'h0900);
        x1(0, 0, 64'h8105, 4'h0, 1);               frame(16, 48'h0281);
        x1(0, 0, 64'h05, 4'h0, 1);                 frame(16, 48'h0B00);
        x1(0, 0, 64'h8105, 4'h0, 1);               frame(16, 48'h0B01);
        x1(0, 0, 64'hFFFFFFFFFFFFFFFF, 4'h0, 1);   frame(16, 48'h0F01);
        x1(0, 0, 64'hFFFFFFFFFFFFFFFF, 4'h0, 0);   frame(16, 48'h0C00);
        x1(0, 0, 64'h0, 4'h0, 0);                  frame(16, 48'h0F00);
        x1(0, 0, 64'h8105, 4'h0, 1);               frame(16, 48'h0C01);
        x1(0, 0, 64'h8105, 4'hA, 1);               frame(16, 48'h0A0A);
        x1(1, 0, 64'h8105, 4'hA, 1);               frame(15, 48'h0);
        x1(0, 1, 64'h8105, 4'hA, 1);               frame(16, 48'h0D12);
        x1(0, 1, 64'h8105, 4'hA, 1);               frame(0, 48'h0);
        x1(0, 1, 64'h8105, 4'hA, 1);               frame(16, 48'h0E34);

        do_reset(1'b1);
        x1(0, 0, 64'h0, 4'h0, 1);
        e3 = '{chk: 1'b1, ferr: 1'b0, badr: 1'b0, dig: '0,
               inten: '0, en: 3'b111};
        frame(48, 48'h0C01_0C01_0C01);
        x1(0, 0, 64'h03, 4'h0, 1);
        e3 = '{chk: 1'b1, ferr: 1'b0, badr: 1'b0,
               dig: {64'h01, 64'h02, 64'h03}, inten: '0, en: 3'b111};
        frame(48, 48'h0101_0102_0103);

        load = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        do_reset(1'b0);
        x1(0, 0, 64'h0, 4'h0, 0);
        e3 = '{chk: 1'b1, ferr: 1'b0, badr: 1'b0, dig: '0,
               inten: '0, en: 3'b000};
        frame(16, 48'h0107);
        x1(0, 0, 64'h07, 4'h0, 1);
        e3 = '{chk: 1'b1, ferr: 1'b0, badr: 1'b0, dig: 192'h07,
               inten: '0, en: 3'b001};
        frame(16, 48'h0C01);

        repeat (20) @(negedge clk);
        check("dev1 queue drained", q1.size(), 0);
        check("dev3 queue drained", q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/max7219_chain_moc.md
# max7219_chain_moc

Parametrised bus-functional model of a daisy-chain of MAX7219 LED drivers, used by the clock-display testbenches to check what the serial display driver actually puts on the glass. It oversamples the three-wire serial bus (DIN/CLK/LOAD) in the `i_clk` domain and implements the full MAX7219 register set per device: Code-B decode, scan limit, shutdown and display test. It also drives a DOUT pin for longer chains and flags framing and address errors. It replaces the single-device mock, and is synthesisable so it can also sit in FPGA loopback builds.

## Interface
- `N_DEV`, default 1: number of cascaded devices, 1..8.
- `SYNC_STAGES`, default 2: synchroniser depth on the serial inputs, ≥2.
- `i_clk`  in  1  model clock; all logic on its rising edge.
- `i_reset`  in  1  reset; **synchronous, active-high**.
- `i_serial_din`  in  1  serial data, MSB first.
- `i_serial_clk`  in  1  serial clock; data is taken on its rising edge.
- `i_serial_load`  in  1  LOAD/CS; low while shifting, rising edge commits.
- `o_serial_dout`  out  1  DOUT of the last device, i.e. the chain MSB.
- `o_digits`  out  N_DEV*64  rendered segments; device d, digit k at bits [(d*8+k)*8 +: 8]; bit7 = DP, bits6..0 = segments A..G.
- `o_intensity`  out  N_DEV*4  intensity register per device.
- `o_enable`  out  N_DEV  shutdown register bit per device (1 = normal operation).
- `o_commit`  out  1  one-cycle pulse on each load commit.
- `o_frame_err`  out  1  one-cycle pulse: bit count at commit is not a multiple of 16.
- `o_bad_addr`  out  1  one-cycle pulse: some device received address 0xD or 0xE.

## Operation
- **Input sampling:**
  - Each serial input passes through a `SYNC_STAGES` synchroniser, followed by one edge-detect register.
  - Reset values: clk stages 0, load stages 1 (idle high), din stages 0. This means no false load edge comes out of reset.
- **Shift:**
  - On a detected sclk rise while synced load is 0, the chain register (N_DEV*16 bits) shifts left and takes din into bit 0.
  - `o_serial_dout` is bit N_DEV*16-1.
  - A 4-bit bit counter increments and wraps at 16.
- **Commit:** On a detected load rise:
  - Device d decodes word [d*16 +: 16]: addr = bits[11:8], data = bits[7:0].
  - Device 0 is the device nearest DIN, so it holds the last word sent.
  - Address map:
    - 0x0: no-op.
    - 0x1–0x8: digit 0–7.
    - 0x9: decode mask.
    - 0xA: intensity = data[3:0].
    - 0xB: scan limit = data[2:0].
    - 0xC: enable = data[0].
    - 0xF: test = data[0].
    - 0xD, 0xE: register untouched, `o_bad_addr` pulses.
  - `o_frame_err` pulses if the counter ≠ 0.
  - Counter clears; the chain register is kept, as on the real part.
  - A load with zero clocks re-commits the current words (idempotent).
- **Rendering** (combinational from registers), priority order:
  1. test=1 → all 8 digits 0xFF. This overrides shutdown.
  2. enable=0 → 0x00.
  3. k > scan limit → 0x00.
  4. decode bit k set → {data[7], CodeB(data[3:0])}.
  5. Otherwise the raw register.
- **CodeB font:**
  - 0–9 → decimal glyphs.
  - A → "-", B → E, C → H, D → L, E → P, F → blank.
  - data[6:4] are ignored.
- **Register reset values:** all digit, decode, intensity, scan and test registers 0, and enable 0. Every output is therefore 0 after reset, including pulses and `o_serial_dout`.

## Timing
- Input-to-output latency is SYNC_STAGES+2 `i_clk` cycles, measured from the input change to the registered update. The same figure applies to `o_digits` and to all three pulses after a LOAD rise.
- Each sclk high phase and each sclk low phase must last ≥ SYNC_STAGES+1 `i_clk` periods. Load setup to the last sclk rise carries the same requirement.
- If an sclk rise and a load rise are sampled in the same cycle, synced load=1 suppresses the shift, and the commit uses the register without that bit.
- `i_reset` mid-frame clears the chain register, the counter and all device registers; no commit occurs. A load rise in the reset cycle is ignored.
- The bit counter wraps, so 32 clocks into a 1-device chain is legal: the overflow passes out on DOUT and no error is flagged.

## Structure
- Package `max7219_pkg`:
  - address localparams (NOOP, DIGIT0..7, DECODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, TEST);
  - the CodeB glyph constants;
  - the `WORD_BITS = 16` constant.
- Sub-module `max7219_code_b`: combinational 4-bit → 7-segment CodeB decoder, instantiated N_DEV*8 times in a generate loop.
- Per-device register bank as a generate loop; a single shared chain register and counter.

## Test plan
- **Reset.** Stimulus: apply reset. Response: `o_digits`=0, `o_enable`=0, `o_serial_dout`=0, and no pulses, including with load held high through reset.
- **Single device, normal write.** Stimulus: N_DEV=1; write 0x0C01, 0x0B07, 0x09FF, then 0x0105. Response: digit0=0x5B ("5"), `o_commit` pulses 4 times, and `o_frame_err` stays 0.
- **Raw mode, scan limit and test override.** Stimulus: write 0x0900, 0x0281, 0x0B00. Response: digit1=0x00 (blanked by scan limit). Stimulus: then write 0x0B01. Response: digit1=0x81. Stimulus: then write 0x0F01 followed by 0x0C00. Response: all digits 0xFF.
- **Cascade.** Stimulus: N_DEV=3; one frame of 0x0101, 0x0102, 0x0103. Response: dev2 digit0 raw=0x01, dev0 digit0=0x03. `o_serial_dout` must equal the bit shifted in 48 clocks earlier.
- **Errors.** Stimulus: 15-bit frame. Response: `o_frame_err` pulses. Stimulus: word 0x0D12. Response: `o_bad_addr` pulses, registers unchanged.
- **Reset mid-frame.** Stimulus: reset after 8 bits, then a clean write of 0x0107. Response: only 0x0107 lands, with no frame error.
